uart_program_loader: RTL

- Writer-side master for the CPU's byte-wide program-memory write port (pmWrEn / pm_addr / instructionIn).
- Receives a framed program image over an 8N1 UART line and writes each payload byte to consecutive program-memory addresses starting at 0.
- Holds the CPU in reset while loading. Releases the CPU reset only after a valid checksum.
- Sits at the top level between the external rx pin and the CPU's program-memory write inputs and rst input.

---
 rtl/uart_program_loader.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/uart_program_loader.sv
// UART program loader: receives an A5/LEN/payload/CSUM frame over 8N1 serial and
// writes the payload into program memory, holding the CPU in reset until a good checksum.
module uart_program_loader #(
  parameter int CLKS_PER_BIT = 16,
  parameter int ADD_WIDTH    = 7,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic                  pmWrEn,
  output logic [ADD_WIDTH-1:0]  pm_addr,
  output logic [DATA_WIDTH-1:0] instructionIn,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  load_done,
  output logic                  load_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [7:0]    HDR     = 8'hA5;
  localparam logic [7:0]    MAX_LEN = 8'd128;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {WAIT_HDR, GET_LEN, GET_DATA, GET_CSUM, DONE, ERR} ld_state_t;

  rx_state_t rx_state, rx_nxt;
  ld_state_t ld_state, ld_nxt;

  logic                 rx_meta, rx_sync;
  logic [CW-1:0]        clk_cnt;
  logic [2:0]           bit_idx;
  logic [7:0]           rx_byte;
  logic                 cnt_tick;
  logic                 byte_valid, frame_err;

  logic [7:0]           checksum;
  logic [7:0]           remaining;
  logic [ADD_WIDTH-1:0] index;
  logic                 wr_req, frame_start;

  // UART receiver state register and bit-timing datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_state <= RX_IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      rx_byte  <= '0;
    end else begin
      rx_meta  <= rx;
      rx_sync  <= rx_meta;
      rx_state <= rx_nxt;
      if (rx_state == RX_IDLE || cnt_tick)
        clk_cnt <= '0;
      else
        clk_cnt <= clk_cnt + 1'b1;
      if (rx_state == RX_START)
        bit_idx <= '0;
      if (rx_state == RX_DATA && cnt_tick) begin
        rx_byte <= {rx_sync, rx_byte[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  // Start check waits half a bit; every later sample is one full bit apart
  always_comb begin
    rx_nxt     = rx_state;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    cnt_tick   = (rx_state == RX_START) ? (clk_cnt == HALF_M1) : (clk_cnt == FULL_M1);
    case (rx_state)
      RX_IDLE:  if (!rx_sync) rx_nxt = RX_START;
      RX_START: if (cnt_tick) rx_nxt = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (cnt_tick && bit_idx == 3'd7) rx_nxt = RX_STOP;
      RX_STOP: begin
        if (cnt_tick) begin
          rx_nxt     = RX_IDLE;
          byte_valid = rx_sync;
          frame_err  = !rx_sync;
        end
      end
      default:  rx_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    ld_nxt      = ld_state;
    wr_req      = 1'b0;
    frame_start = 1'b0;
    case (ld_state)
      WAIT_HDR, DONE, ERR: begin
        if (byte_valid && rx_byte == HDR) begin
          ld_nxt      = GET_LEN;
          frame_start = 1'b1;
        end
      end
      GET_LEN: begin
        if (frame_err)
          ld_nxt = ERR;
        else if (byte_valid)
          ld_nxt = (rx_byte != 8'd0 && rx_byte <= MAX_LEN) ? GET_DATA : ERR;
      end
      GET_DATA: begin
        if (frame_err)
          ld_nxt = ERR;
        else if (byte_valid) begin
          wr_req = 1'b1;
          if (remaining == 8'd1) ld_nxt = GET_CSUM;
        end
      end
      GET_CSUM: begin
        if (frame_err)
          ld_nxt = ERR;
        else if (byte_valid)
          ld_nxt = (rx_byte == checksum) ? DONE : ERR;
      end
      default: ld_nxt = WAIT_HDR;
    endcase
  end

  // Flags are registered from the next state so they move on the same edge as the FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_state      <= WAIT_HDR;
      pmWrEn        <= 1'b0;
      pm_addr       <= '0;
      instructionIn <= '0;
      cpu_rst       <= 1'b1;
      busy          <= 1'b0;
      load_done     <= 1'b0;
      load_err      <= 1'b0;
      checksum      <= '0;
      remaining     <= '0;
      index         <= '0;
    end else begin
      ld_state  <= ld_nxt;
      pmWrEn    <= wr_req;
      cpu_rst   <= (ld_nxt != DONE);
      load_done <= (ld_nxt == DONE);
      load_err  <= (ld_nxt == ERR);
      busy      <= (ld_nxt == GET_LEN) || (ld_nxt == GET_DATA) || (ld_nxt == GET_CSUM);
      if (frame_start) begin
        checksum <= '0;
        index    <= '0;
      end
      if (ld_state == GET_LEN && byte_valid)
        remaining <= rx_byte;
      if (wr_req) begin
        pm_addr       <= index;
        instructionIn <= DATA_WIDTH'(rx_byte);
        index         <= index + 1'b1;
        checksum      <= checksum ^ rx_byte;
        remaining     <= remaining - 8'd1;
      end
    end
  end

endmodule
